// File: rtl/arm_cond_pkg.sv
// Shared ARM condition-code definitions.
//  - COND_* : the 16 encodings of instruction bits [31:28]
//  - FLAG_* : bit positions of N/Z/C/V within the 4-bit CPSR flag nibble
//  - cond_pass(): 1 when an instruction with the given cond field executes
//    under the given flags. Also intended for the ALU/branch unit.
package arm_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v, r;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = !z;
            COND_CS: r = c;
            COND_CC: r = !c;
            COND_MI: r = n;
            COND_PL: r = !n;
            COND_VS: r = v;
            COND_VC: r = !v;
            COND_HI: r = c && !z;
            COND_LS: r = !c || z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = !z && (n == v);
            COND_LE: r = z || (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;      // NV never executes
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Synchronous FIFO with wrap-bit pointers.
//  clk, rst_n      : clock, async active-low reset
//  push_i, wdata_i : write request / data (ignored when full)
//  pop_i           : remove head (ignored when empty)
//  flush_i         : discard all entries; overrides push and pop
//  rdata_o         : head storage word (no write-through bypass)
//  full_o, empty_o : occupancy status
module sync_fifo_ptr #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q;
    logic                          do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '0;   // head reads as zero out of reset
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/cond_issue_queue.sv
// Condition-checking issue queue between fetch and decode.
// Buffers fetched instructions; the head is evaluated against CPSR flags.
// Passing heads are offered to decode (valid/ready); failing heads are
// dropped without a handshake and counted.
//  clk, rst_n                 : clock, async active-low reset
//  in_valid/in_ready/in_data  : fetch side (in_ready = !full)
//  flags, flags_valid         : CPSR {N,Z,C,V}; low valid stalls the head
//  out_valid/out_ready/out_data : decode side
//  flush                      : discard all queued entries
//  skip_pulse                 : registered 1-cycle pulse per dropped instr
//  issued_cnt, skipped_cnt    : saturating statistics counters
module cond_issue_queue
    import arm_cond_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        flags,
    input  logic              flags_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic              skip_pulse,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  skipped_cnt
);
    logic             full, empty, head_pass;
    logic             issue, drop, push;
    logic             skip_q;
    logic [CNT_W-1:0] issued_q, skipped_q;

    sync_fifo_ptr #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (issue || drop),
        .flush_i (flush),
        .wdata_i (in_data),
        .rdata_o (out_data),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head_pass = cond_pass(out_data[DATA_W-1 -: 4], flags);
    assign in_ready  = !full;
    assign out_valid = !empty && flags_valid && head_pass;

    // Flush suppresses every state change this cycle, including a handshake
    // decode may have seen; decode treats that as a withdrawal.
    assign push  = in_valid && in_ready && !flush;
    assign issue = out_valid && out_ready && !flush;
    assign drop  = !empty && flags_valid && !head_pass && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_q    <= 1'b0;
            issued_q  <= '0;
            skipped_q <= '0;
        end else begin
            skip_q <= drop;
            if (issue && (issued_q != '1))  issued_q  <= issued_q + 1'b1;
            if (drop && (skipped_q != '1))  skipped_q <= skipped_q + 1'b1;
        end
    end

    assign skip_pulse  = skip_q;
    assign issued_cnt  = issued_q;
    assign skipped_cnt = skipped_q;

endmodule

// File: tb/tb_cond_issue_queue.sv
// Randomised + directed bench for cond_issue_queue with a queue-based model.
module tb_cond_issue_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, flush, flags_valid, skip_pulse;
    logic [31:0] in_data, out_data;
    logic [3:0]  flags;
    logic [CNT_W-1:0] issued_cnt, skipped_cnt;

    cond_issue_queue #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flags(flags), .flags_valid(flags_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .skip_pulse(skip_pulse),
        .issued_cnt(issued_cnt), .skipped_cnt(skipped_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    logic [31:0] mq[$];
    int  m_iss, m_skp;
    bit  m_skip;
    int  errors, checks, pulses;

    // cond[3:1] selects a base predicate, cond[0] inverts it (AL^1 = NV).
    function automatic bit ref_pass(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_iss = 0; m_skp = 0; m_skip = 0;
    endtask

    task automatic check_cycle();
        bit ov;
        ov = (mq.size() > 0) && flags_valid && ref_pass(mq[0][31:28], flags);
        chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < DEPTH});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ov});
        if (ov) chk("out_data", out_data, mq[0]);
        chk("skip_pulse", {31'd0, skip_pulse}, {31'd0, m_skip});
        chk("issued_cnt", 32'(issued_cnt), 32'(sat(m_iss)));
        chk("skipped_cnt", 32'(skipped_cnt), 32'(sat(m_skp)));
        if (skip_pulse) pulses++;
    endtask

    task automatic model_step();
        bit full, has, p, iss, drp;
        if (!rst_n) begin
            model_clear();
        end else if (flush) begin
            mq.delete();
            m_skip = 0;
        end else begin
            full = (mq.size() == DEPTH);
            has  = (mq.size() > 0);
            p    = has && ref_pass(mq[0][31:28], flags);
            iss  = has && flags_valid && p && out_ready;
            drp  = has && flags_valid && !p;
            m_skip = drp;
            if (iss) m_iss++;
            if (drp) m_skp++;
            if (iss || drp) void'(mq.pop_front());
            if (in_valid && !full) mq.push_back(in_data);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic push1(input logic [31:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        errors = 0; checks = 0; pulses = 0;
        model_clear();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hE000_0001;
        flags = 4'b0000; flags_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;

        // 1. reset held with in_valid high
        repeat (3) begin
            tick();
            chk("rst in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst out_data", out_data, 32'd0);
            chk("rst issued", 32'(issued_cnt), 32'd0);
            chk("rst skipped", 32'(skipped_cnt), 32'd0);
        end
        in_valid = 1'b0; rst_n = 1'b1;
        tick();
        chk("post-rst out_valid", {31'd0, out_valid}, 32'd0);

        // 2. EQ issues, NE drops under Z
        flags = 4'b0100; pulses = 0;
        push1(32'h0A00_0001);
        push1(32'h1A00_0002);
        idle(4);
        chk("t2 pulses", 32'(pulses), 32'd1);
        chk("t2 issued", 32'(issued_cnt), 32'd1);
        chk("t2 skipped", 32'(skipped_cnt), 32'd1);

        // 3. HI/LS and NV
        flags = 4'b0010;
        push1(32'h8000_0000); push1(32'h9000_0000); idle(3);
        chk("t3 C issued", 32'(issued_cnt), 32'd2);
        chk("t3 C skipped", 32'(skipped_cnt), 32'd2);
        flags = 4'b0110;
        push1(32'h8000_0000); push1(32'h9000_0000); idle(3);
        chk("t3 ZC issued", 32'(issued_cnt), 32'd3);
        chk("t3 ZC skipped", 32'(skipped_cnt), 32'd3);
        push1(32'hF000_0000); idle(3);
        chk("t3 NV skipped", 32'(skipped_cnt), 32'd4);

        // 4. fill, overflow attempt, then streaming through pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push1(32'hE000_0010 + 32'(i));
        chk("t4 full in_ready", {31'd0, in_ready}, 32'd0);
        chk("t4 head", out_data, 32'hE000_0010);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'hE000_0020 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        idle(6);
        chk("t4 issued", 32'(issued_cnt), 32'd14);

        // 5. flag stall
        flags_valid = 1'b0;
        push1(32'hE000_0055);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5 stall out_valid", {31'd0, out_valid}, 32'd0);
        end
        flags_valid = 1'b1; #1;
        chk("t5 release out_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("t5 issued", 32'(issued_cnt), 32'd15);

        // 6. flush beats push and pop
        out_ready = 1'b0;
        push1(32'hE000_0061); push1(32'hE000_0062); push1(32'hE000_0063);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hE000_0099; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t6 out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6 in_ready", {31'd0, in_ready}, 32'd1);
        chk("t6 issued", 32'(issued_cnt), 32'd15);
        chk("t6 skipped", 32'(skipped_cnt), 32'd4);
        idle(2);

        // 7. randomised run with one mid-run async reset
        for (int i = 0; i < 600; i++) begin
            if (i == 100) begin
                rst_n = 1'b0;
                model_clear();
            end
            if (i == 102) rst_n = 1'b1;
            in_valid    = ($urandom % 10) < 6;
            in_data     = $urandom;
            flags       = 4'($urandom);
            flags_valid = ($urandom % 10) < 8;
            out_ready   = ($urandom % 10) < 7;
            flush       = ($urandom % 50) == 0;
            tick();
        end
        flush = 1'b0; flags_valid = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'hE000_0000;
        repeat (80) tick();
        in_data = 32'hF000_0000;
        repeat (80) tick();
        in_valid = 1'b0;
        idle(4);
        chk("sat issued", 32'(issued_cnt), 32'(CMAX));
        chk("sat skipped", 32'(skipped_cnt), 32'(CMAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
